mdu_hilo: RTL and testbench

Multi-cycle multiply/divide responder for the EX stage. It accepts one operation per issue, holds the HI/LO register pair, and drives a busy stall back to the hazard unit. It also provides the HI/LO read path for mfhi/mflo. It sits beside the main ALU and takes already-forwarded operands from EX.

---
 rtl/mdu_hilo.sv | 112 +++++++++++
 tb/tb_mdu_hilo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit owning the HI/LO pair.
// Results are computed at issue and committed after the configured latency.
module mdu_hilo #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        clr,
    input  logic        rd_sel,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, hi_q, hi_d, lo_q, lo_d, pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        busy_q, busy_d, done_q, done_d, pend_wr_q, pend_wr_d;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] sdv, udv, squo, srem, uquo, urem;
    logic        is_mul, is_div, b_zero, ovf;

    assign is_mul = op == 4'd1 || op == 4'd2;
    assign is_div = op == 4'd3 || op == 4'd4;
    assign b_zero = b == 32'd0;
    assign ovf    = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    // Divisor of 1 covers both the /0 guard and the INT_MIN/-1 overflow (q=a, r=0)
    assign sdv    = (b_zero || ovf) ? 32'd1 : b;
    assign udv    = b_zero ? 32'd1 : b;
    assign squo   = $signed(a) / $signed(sdv);
    assign srem   = $signed(a) % $signed(sdv);
    assign uquo   = a / udv;
    assign urem   = a % udv;
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign res    = op == 4'd1 ? prod_s : op == 4'd2 ? prod_u :
                    op == 4'd3 ? {srem, squo} : {urem, uquo};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start && !clr) begin
                if (is_mul || is_div) begin
                    state_d   = RUN;
                    busy_d    = 1'b1;
                    cnt_d     = is_mul ? 32'(MUL_CYCLES) : 32'(DIV_CYCLES);
                    pend_hi_d = res[63:32];
                    pend_lo_d = res[31:0];
                    pend_wr_d = !(is_div && b_zero);
                end else if (op == 4'd5) begin
                    hi_d = a;
                end else if (op == 4'd6) begin
                    lo_d = a;
                end
            end
        end else if (clr) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = 32'd0;
        end else if (cnt_q == 32'd1) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = 32'd0;
            hi_d    = pend_wr_q ? pend_hi_q : hi_q;
            lo_d    = pend_wr_q ? pend_lo_q : lo_q;
        end else begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rdata = rd_sel ? hi_q : lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed scenario checks for mdu_hilo timing and HI/LO results.
module tb_mdu_hilo;
    logic        clk, reset, start, clr, rd_sel;
    logic [3:0]  op;
    logic [31:0] a, b, rdata;
    logic        busy, done;
    int          checks = 0;
    int          fails = 0;

    mdu_hilo #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .clr(clr), .rd_sel(rd_sel), .rdata(rdata), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset) assert (!(start && busy)) else $error("start issued while busy");

    task automatic read(input logic s, output logic [31:0] v);
        rd_sel = s;
        #1 v = rdata;
    endtask

    // Issue at a negedge, then count busy cycles up to the commit edge
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int n, output logic d);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        d = done;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        read(1'b1, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL reset_hi got %h want 00000000", v); end
        read(1'b0, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL reset_lo got %h want 00000000", v); end
    endtask

    task automatic test_multu;
        int n; logic d; logic [31:0] v;
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, d);
        checks++; if (n !== 5) begin fails++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
        checks++; if (d !== 1'b1) begin fails++; $display("FAIL multu_done got %b want 1", d); end
        read(1'b1, v);
        checks++; if (v !== 32'hFFFF_FFFE) begin fails++; $display("FAIL multu_hi got %h want fffffffe", v); end
        read(1'b0, v);
        checks++; if (v !== 32'h0000_0001) begin fails++; $display("FAIL multu_lo got %h want 00000001", v); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL multu_done_pulse got %b want 0", done); end
    endtask

    task automatic test_back_to_back;
        int n; logic d; logic [31:0] v;
        run_op(4'd1, 32'hFFFF_FFFD, 32'h0000_0007, n, d);
        checks++; if (n !== 5) begin fails++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
        read(1'b1, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", v); end
        read(1'b0, v);
        checks++; if (v !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", v); end
        run_op(4'd4, 32'd7, 32'd2, n, d);
        checks++; if (n !== 10) begin fails++; $display("FAIL divu_busy_cycles got %0d want 10", n); end
        checks++; if (d !== 1'b1) begin fails++; $display("FAIL divu_done got %b want 1", d); end
        read(1'b0, v);
        checks++; if (v !== 32'd3) begin fails++; $display("FAIL divu_lo got %h want 00000003", v); end
        read(1'b1, v);
        checks++; if (v !== 32'd1) begin fails++; $display("FAIL divu_hi got %h want 00000001", v); end
    endtask

    task automatic test_div;
        int n; logic d; logic [31:0] v;
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, n, d);
        checks++; if (n !== 10) begin fails++; $display("FAIL div_busy_cycles got %0d want 10", n); end
        read(1'b0, v);
        checks++; if (v !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", v); end
        read(1'b1, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", v); end
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n, d);
        read(1'b0, v);
        checks++; if (v !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", v); end
        read(1'b1, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL div_ovf_hi got %h want 00000000", v); end
    endtask

    task automatic test_mthi_mtlo;
        int n; logic d; logic [31:0] v;
        @(negedge clk);
        start = 1'b1; op = 4'd5; a = 32'h1234_5678;
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got %b want 0", busy); end
        read(1'b1, v);
        checks++; if (v !== 32'h1234_5678) begin fails++; $display("FAIL mthi_hi got %h want 12345678", v); end
        @(negedge clk);
        start = 1'b1; op = 4'd6; a = 32'h9ABC_DEF0;
        @(posedge clk);
        #1 start = 1'b0;
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done got %b want 0", done); end
        read(1'b0, v);
        checks++; if (v !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo_lo got %h want 9abcdef0", v); end
        run_op(4'd4, 32'd55, 32'd0, n, d);
        checks++; if (n !== 10) begin fails++; $display("FAIL div0_busy_cycles got %0d want 10", n); end
        checks++; if (d !== 1'b1) begin fails++; $display("FAIL div0_done got %b want 1", d); end
        read(1'b1, v);
        checks++; if (v !== 32'h1234_5678) begin fails++; $display("FAIL div0_hi got %h want 12345678", v); end
        read(1'b0, v);
        checks++; if (v !== 32'h9ABC_DEF0) begin fails++; $display("FAIL div0_lo got %h want 9abcdef0", v); end
    endtask

    task automatic test_clr;
        logic [31:0] v;
        logic        seen;
        @(negedge clk);
        start = 1'b1; op = 4'd1; a = 32'd2; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL clr_busy got %b want 0", busy); end
        seen = done;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | done;
        end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL clr_no_done got %b want 0", seen); end
        read(1'b0, v);
        checks++; if (v !== 32'h9ABC_DEF0) begin fails++; $display("FAIL clr_lo got %h want 9abcdef0", v); end
        read(1'b1, v);
        checks++; if (v !== 32'h1234_5678) begin fails++; $display("FAIL clr_hi got %h want 12345678", v); end
        @(negedge clk);
        start = 1'b1; clr = 1'b1; op = 4'd6; a = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0; clr = 1'b0;
        read(1'b0, v);
        checks++; if (v !== 32'h9ABC_DEF0) begin fails++; $display("FAIL clr_mtlo_lo got %h want 9abcdef0", v); end
    endtask

    task automatic test_async_reset;
        int n; logic d; logic [31:0] v;
        @(negedge clk);
        start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL areset_done got %b want 0", done); end
        read(1'b1, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL areset_hi got %h want 00000000", v); end
        @(negedge clk);
        read(1'b0, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL areset_lo got %h want 00000000", v); end
        reset = 1'b1;
        run_op(4'd2, 32'd2, 32'd3, n, d);
        checks++; if (n !== 5) begin fails++; $display("FAIL post_reset_busy_cycles got %0d want 5", n); end
        read(1'b0, v);
        checks++; if (v !== 32'd6) begin fails++; $display("FAIL post_reset_lo got %h want 00000006", v); end
        read(1'b1, v);
        checks++; if (v !== 32'd0) begin fails++; $display("FAIL post_reset_hi got %h want 00000000", v); end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; clr = 1'b0; rd_sel = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        reset = 1'b1;
        test_multu;
        test_back_to_back;
        test_div;
        test_mthi_mtlo;
        test_clr;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
